joypad_port: RTL and testbench

- Responder side of the CPU controller-port interface.
- Consumes the CPU's `naddr4016r`, `naddr4017r` and `addr4016w` strobes, and returns serial button data on the CPU data bus for reads of $4016/$4017.
- Emulates two standard 8-button pads, each a 4021-style parallel-in/serial-out register, fed from raw board button inputs.
- Sits on the system bus beside RAM/PPU decode; the bus mux selects `data_out` when `data_oe` is high.

---
 rtl/joypad_pkg.sv | 25 ++
 rtl/joypad_port_if.sv | 14 +
 rtl/joypad_shifter.sv | 89 ++++++++
 rtl/joypad_port.sv | 77 +++++++
 tb/tb_joypad_port.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/joypad_pkg.sv
// Shared constants for the controller-port block.
// The optional button debounce is enabled by defining JOYPAD_DEBOUNCE_EN;
// it is off by default, so the pads load straight from the synchronizers.
package joypad_pkg;

  // Button bit positions within a pad vector.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int JOY_BUTTONS = 8;
  localparam int JOY_CNT_W   = 4;

  // Upper bus bits returned during port reads; only bits 7:5 are driven.
  localparam logic [7:0] OPEN_BUS_BITS_DEFAULT = 8'h40;

  typedef logic [JOY_BUTTONS-1:0] btn_vec_t;
  typedef logic [JOY_CNT_W-1:0]   btn_cnt_t;

endpackage

// File: rtl/joypad_port_if.sv
// CPU-side controller-port bus: read strobes, OUT latch and returned data.
interface joypad_port_if;
  logic       naddr4016r;
  logic       naddr4017r;
  logic [2:0] addr4016w;
  logic [7:0] data_out;
  logic       data_oe;

  // CPU drives the strobes and latch, the port answers with data.
  modport master (output naddr4016r, output naddr4017r, output addr4016w,
                  input data_out, input data_oe);
  modport slave  (input naddr4016r, input naddr4017r, input addr4016w,
                  output data_out, output data_oe);
endinterface

// File: rtl/joypad_shifter.sv
// One 4021-style pad: button synchronizer, optional debounce (JOYPAD_DEBOUNCE_EN),
// parallel load on strobe, and one right shift at the end of each read pulse.
import joypad_pkg::*;

module joypad_shifter (
  input  logic     clock,
  input  logic     reset,
  input  logic     strobe,
  input  logic     nread,
  input  btn_vec_t buttons_raw,
  input  logic     tick,
  output logic     serial_bit
);

  localparam btn_cnt_t CNT_DONE = btn_cnt_t'(JOY_BUTTONS);

  btn_vec_t r_sync1;
  btn_vec_t r_btn_s;
  btn_vec_t w_src;
  btn_vec_t r_shift;
  btn_cnt_t r_cnt;
  logic     r_read_d;
  logic     w_pulse_end;

  // Two-flop synchronizer for the asynchronous board buttons.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_sync1 <= '0;
      r_btn_s <= '0;
    end else begin
      r_sync1 <= buttons_raw;
      r_btn_s <= r_sync1;
    end
  end

`ifdef JOYPAD_DEBOUNCE_EN
  btn_vec_t r_prev;
  btn_vec_t r_db;
  btn_vec_t w_agree;

  assign w_agree = ~(r_btn_s ^ r_prev);

  // Per-tick sampling; a bit is accepted only when two consecutive ticks agree.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev <= '0;
      r_db   <= '0;
    end else if (tick) begin
      r_prev <= r_btn_s;
      r_db   <= (r_db & ~w_agree) | (r_btn_s & w_agree);
    end
  end

  assign w_src = r_db;
`else
  logic w_unused_tick;
  assign w_unused_tick = tick;
  assign w_src         = r_btn_s;
`endif

  // The registered read flag is active-high, so clearing it on reset means
  // "no read seen" and the first rising nread afterwards is not a pulse end.
  assign w_pulse_end = r_read_d & nread;

  // Parallel load while strobe is high, otherwise one shift per completed read.
  always_ff @(posedge clock) begin
    // NOTE: the shift register is reset explicitly to all ones; it is real
    // state that reads observe, not storage that may start undefined.
    if (reset) begin
      r_shift  <= '1;
      r_cnt    <= CNT_DONE;
      r_read_d <= 1'b0;
    end else begin
      r_read_d <= ~nread;
      if (strobe) begin
        r_shift <= w_src;
        r_cnt   <= '0;
      end else if (w_pulse_end) begin
        r_shift <= {1'b1, r_shift[JOY_BUTTONS-1:1]};
        r_cnt   <= (r_cnt == CNT_DONE) ? CNT_DONE : r_cnt + 1'b1;
      end
    end
  end

  assign serial_bit = (r_cnt < CNT_DONE) ? r_shift[0] : 1'b1;

endmodule

// File: rtl/joypad_port.sv
// Controller-port responder for CPU reads of $4016/$4017.
// Optional debounce prescaler enabled by JOYPAD_DEBOUNCE_EN (default off).
import joypad_pkg::*;

module joypad_port #(
  parameter logic [7:0]  OPEN_BUS_BITS   = OPEN_BUS_BITS_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 17898
) (
  input  logic          clock,
  input  logic          reset,
  joypad_port_if.slave  bus,
  input  btn_vec_t      buttons1_raw,
  input  btn_vec_t      buttons2_raw
);

  logic       w_tick;
  logic       w_bit1;
  logic       w_bit2;
  logic [7:0] w_data_out;
  logic [1:0] w_unused_addr;

  // Only the strobe bit of the OUT latch matters to the pads.
  assign w_unused_addr = bus.addr4016w[2:1];

`ifdef JOYPAD_DEBOUNCE_EN
  localparam int unsigned PRESC_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DEBOUNCE_CYCLES - 1);

  logic [PRESC_W-1:0] r_presc;

  assign w_tick = (r_presc == PRESC_LAST);

  // Shared debounce prescaler, ticking once per DEBOUNCE_CYCLES clocks.
  always_ff @(posedge clock) begin
    if (reset)       r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (DEBOUNCE_CYCLES == 0);
  assign w_tick       = 1'b0;
`endif

  joypad_shifter u_pad1 (
    .clock       (clock),
    .reset       (reset),
    .strobe      (bus.addr4016w[0]),
    .nread       (bus.naddr4016r),
    .buttons_raw (buttons1_raw),
    .tick        (w_tick),
    .serial_bit  (w_bit1)
  );

  joypad_shifter u_pad2 (
    .clock       (clock),
    .reset       (reset),
    .strobe      (bus.addr4016w[0]),
    .nread       (bus.naddr4017r),
    .buttons_raw (buttons2_raw),
    .tick        (w_tick),
    .serial_bit  (w_bit2)
  );

  // Read-data mux; port 1 has priority when both strobes are low.
  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned
    // and a latch cannot be inferred.
    w_data_out = 8'h00;
    if (!bus.naddr4016r)      w_data_out = {OPEN_BUS_BITS[7:5], 4'b0000, w_bit1};
    else if (!bus.naddr4017r) w_data_out = {OPEN_BUS_BITS[7:5], 4'b0000, w_bit2};
  end

  assign bus.data_out = w_data_out;
  assign bus.data_oe  = ~bus.naddr4016r | ~bus.naddr4017r;

endmodule

// File: tb/tb_joypad_port.sv
// Self-checking bench for joypad_port; expected read data is queued when a
// read is driven and compared when the port returns it.
`timescale 1ns/1ps
module tb_joypad_port;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] buttons1_raw;
  logic [7:0] buttons2_raw;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  joypad_port_if bus();

  joypad_port #(.OPEN_BUS_BITS(8'h40), .DEBOUNCE_CYCLES(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .buttons1_raw (buttons1_raw),
    .buttons2_raw (buttons2_raw)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Change buttons and allow time for synchronizer (and debounce) to settle.
  task automatic set_buttons(input logic [7:0] b1, input logic [7:0] b2);
    buttons1_raw = b1;
    buttons2_raw = b2;
    repeat (20) @(posedge clock);
    #1;
  endtask

  task automatic strobe_load();
    bus.addr4016w = 3'b001;
    @(posedge clock); #1;
    bus.addr4016w = 3'b000;
  endtask

  // sel: 1 = $4016, 2 = $4017, 3 = both. Pushes the expected byte per cycle
  // of the pulse, pops and compares while the pulse is low, then checks idle.
  task automatic read_port(input int sel, input int len, input logic [7:0] exp, input string name);
    logic [7:0] e;
    for (int i = 0; i < len; i++) sb_q.push_back(exp);
    if (sel[0]) bus.naddr4016r = 1'b0;
    if (sel[1]) bus.naddr4017r = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      e = sb_q.pop_front();
      checks++;
      if (bus.data_out !== e || bus.data_oe !== 1'b1) begin
        errors++;
        $display("FAIL %s[%0d]: data_out=%h data_oe=%b, expected data_out=%h data_oe=1",
                 name, i, bus.data_out, bus.data_oe, e);
      end
      @(posedge clock); #1;
    end
    bus.naddr4016r = 1'b1;
    bus.naddr4017r = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.data_out !== 8'h00 || bus.data_oe !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: data_out=%h data_oe=%b, expected 00/0", name, bus.data_out, bus.data_oe);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.data_out !== 8'h00 || bus.data_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: data_out=%h data_oe=%b, expected 00/0", bus.data_out, bus.data_oe);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    read_port(1, 1, 8'h41, "reset_read4016");
    read_port(2, 1, 8'h41, "reset_read4017");
  endtask

  task automatic test_serial();
    logic [7:0] pat;
    pat = 8'b1000_0101;
    set_buttons(pat, 8'h00);
    strobe_load();
    for (int i = 0; i < 10; i++)
      read_port(1, 1, {3'b010, 4'b0, (i < 8) ? pat[i] : 1'b1}, $sformatf("serial_bit%0d", i));
  endtask

  task automatic test_strobe_held();
    bus.addr4016w = 3'b001;
    set_buttons(8'h00, 8'h00);
    read_port(1, 1, 8'h40, "held_a0");
    set_buttons(8'h01, 8'h00);
    read_port(1, 1, 8'h41, "held_a1");
    read_port(1, 1, 8'h41, "held_a1_again");
    bus.addr4016w = 3'b110;
    @(posedge clock); #1;
    read_port(1, 1, 8'h41, "held_release_bit0");
    read_port(1, 1, 8'h40, "held_release_bit1");
  endtask

  task automatic test_long_pulse();
    set_buttons(8'h00, 8'h02);
    strobe_load();
    read_port(2, 3, 8'h40, "long_pulse");
    read_port(2, 1, 8'h41, "long_next_bit1");
    read_port(2, 1, 8'h40, "long_next_bit2");
  endtask

  task automatic test_both_ports();
    set_buttons(8'h01, 8'h02);
    strobe_load();
    read_port(3, 1, 8'h41, "both_port1_priority");
    read_port(1, 1, 8'h40, "both_port1_shifted");
    read_port(2, 1, 8'h41, "both_port2_shifted");
  endtask

  task automatic test_button_change();
    logic [7:0] pat;
    pat = 8'h0F;
    set_buttons(pat, 8'h00);
    strobe_load();
    read_port(1, 1, {7'b0100000, pat[0]}, "change_bit0");
    read_port(1, 1, {7'b0100000, pat[1]}, "change_bit1");
    set_buttons(8'hF0, 8'h00);
    for (int i = 2; i < 8; i++)
      read_port(1, 1, {7'b0100000, pat[i]}, $sformatf("change_bit%0d", i));
  endtask

  task automatic test_reset_mid_read();
    set_buttons(8'h00, 8'h00);
    strobe_load();
    for (int i = 0; i < 3; i++) read_port(1, 1, 8'h40, $sformatf("midrst_pre%0d", i));
    bus.naddr4016r = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.data_out !== 8'h41 || bus.data_oe !== 1'b1) begin
      errors++;
      $display("FAIL midrst_during: data_out=%h data_oe=%b, expected 41/1", bus.data_out, bus.data_oe);
    end
    @(posedge clock); #1;
    bus.naddr4016r = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) read_port(1, 1, 8'h41, $sformatf("midrst_post%0d", i));
  endtask

`ifdef JOYPAD_DEBOUNCE_EN
  task automatic test_debounce();
    set_buttons(8'h00, 8'h00);
    buttons1_raw = 8'h01;
    repeat (3) @(posedge clock);
    #1;
    buttons1_raw = 8'h00;
    repeat (20) @(posedge clock);
    #1;
    strobe_load();
    read_port(1, 1, 8'h40, "debounce_glitch");
    buttons1_raw = 8'h01;
    repeat (10) @(posedge clock);
    #1;
    strobe_load();
    read_port(1, 1, 8'h41, "debounce_stable");
  endtask
`endif

  initial begin
    reset          = 1'b1;
    buttons1_raw   = 8'h00;
    buttons2_raw   = 8'h00;
    bus.naddr4016r = 1'b1;
    bus.naddr4017r = 1'b1;
    bus.addr4016w  = 3'b000;
    #1;
    test_reset();
    test_serial();
    test_strobe_held();
    test_long_pulse();
    test_both_ports();
    test_button_change();
    test_reset_mid_read();
`ifdef JOYPAD_DEBOUNCE_EN
    test_debounce();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
